// File: rtl/serving_arb_pkg.sv
// Shared types and constants for the serving RAM arbiter.
package serving_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        EXT  = 2'd2
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_EXT = 1'b1;

    localparam int STARVE_W = 8;

endpackage

// File: rtl/serving_mem_arbiter_if.sv
// Bus bundle between the arbiter and its two requesters plus the serving RAM.
// Handshake: a requester holds stb and its request fields stable until it sees ack; a cycle
// with stb and ack both high completes the transfer, and dropping stb before ack aborts it.
interface serving_mem_arbiter_if #(
    parameter int AW = 12
);
    logic [AW-3:0] i_cpu_adr;
    logic [31:0]   i_cpu_dat;
    logic [3:0]    i_cpu_sel;
    logic          i_cpu_we;
    logic          i_cpu_stb;
    logic [31:0]   o_cpu_rdt;
    logic          o_cpu_ack;

    logic [AW-3:0] i_ext_adr;
    logic [31:0]   i_ext_dat;
    logic [3:0]    i_ext_sel;
    logic          i_ext_we;
    logic          i_ext_stb;
    logic [31:0]   o_ext_rdt;
    logic          o_ext_ack;

    logic [AW-3:0] o_ram_adr;
    logic [31:0]   o_ram_dat;
    logic [3:0]    o_ram_sel;
    logic          o_ram_we;
    logic          o_ram_cyc;
    logic [31:0]   i_ram_rdt;
    logic          i_ram_ack;

    logic          sel_radr;
    logic          sel_wadr;
    logic          sel_wdata;
    logic          sel_rdata;
    logic          sel_wen;
    logic          o_busy;
    logic [1:0]    dbg_state;

    modport master (
        output i_cpu_adr, i_cpu_dat, i_cpu_sel, i_cpu_we, i_cpu_stb,
        output i_ext_adr, i_ext_dat, i_ext_sel, i_ext_we, i_ext_stb,
        output i_ram_rdt, i_ram_ack,
        input  o_cpu_rdt, o_cpu_ack, o_ext_rdt, o_ext_ack,
        input  o_ram_adr, o_ram_dat, o_ram_sel, o_ram_we, o_ram_cyc,
        input  sel_radr, sel_wadr, sel_wdata, sel_rdata, sel_wen, o_busy, dbg_state
    );

    modport slave (
        input  i_cpu_adr, i_cpu_dat, i_cpu_sel, i_cpu_we, i_cpu_stb,
        input  i_ext_adr, i_ext_dat, i_ext_sel, i_ext_we, i_ext_stb,
        input  i_ram_rdt, i_ram_ack,
        output o_cpu_rdt, o_cpu_ack, o_ext_rdt, o_ext_ack,
        output o_ram_adr, o_ram_dat, o_ram_sel, o_ram_we, o_ram_cyc,
        output sel_radr, sel_wadr, sel_wdata, sel_rdata, sel_wen, o_busy, dbg_state
    );

endinterface

// File: rtl/serving_arb_pick.sv
// Next-owner decision. SERVING_ARB_RR_EN selects round-robin; otherwise CPU has priority
// unless the starve limit has been hit.
module serving_arb_pick
    import serving_arb_pkg::*;
(
    input  logic   cpu_stb,
    input  logic   ext_stb,
    input  logic   last_grant,
    input  logic   starve_hit,
    output state_t next_state
);

`ifdef SERVING_ARB_RR_EN
    logic unused_hit;
    assign unused_hit = starve_hit;
`else
    logic unused_last;
    assign unused_last = last_grant;
`endif

    always_comb begin
        next_state = IDLE;
        if (cpu_stb && ext_stb) begin
`ifdef SERVING_ARB_RR_EN
            next_state = (last_grant == GRANT_EXT) ? CPU : EXT;
`else
            next_state = starve_hit ? EXT : CPU;
`endif
        end else if (cpu_stb) begin
            next_state = CPU;
        end else if (ext_stb) begin
            next_state = EXT;
        end
    end

endmodule

// File: rtl/serving_mem_arbiter.sv
// Registered-grant arbiter for the serving RAM port (CPU bus vs AXI bridge master).
// SERVING_ARB_RR_EN builds round-robin arbitration instead of CPU priority with starve counter.
module serving_mem_arbiter
    import serving_arb_pkg::*;
#(
    parameter int AW           = 12,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    serving_mem_arbiter_if.slave  bus
);

    state_t state, next_state, pick_state;
    logic   is_cpu, is_ext, owner_stb, decide;
    logic   last_grant, starve_hit;

    assign is_cpu    = (state == CPU);
    assign is_ext    = (state == EXT);
    assign owner_stb = is_cpu ? bus.i_cpu_stb : (is_ext ? bus.i_ext_stb : 1'b0);
    // A decision is made from IDLE and on the completing edge, so back-to-back grants skip IDLE.
    assign decide    = (state == IDLE) || (owner_stb && bus.i_ram_ack);

    serving_arb_pick u_pick (
        .cpu_stb    (bus.i_cpu_stb),
        .ext_stb    (bus.i_ext_stb),
        .last_grant (last_grant),
        .starve_hit (starve_hit),
        .next_state (pick_state)
    );

    always_comb begin
        next_state = state;
        if (decide) begin
            next_state = pick_state;
        end else if (!owner_stb) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant <= GRANT_EXT;
        end else if (decide && pick_state == CPU) begin
            last_grant <= GRANT_CPU;
        end else if (decide && pick_state == EXT) begin
            last_grant <= GRANT_EXT;
        end
    end

`ifdef SERVING_ARB_RR_EN
    logic unused_limit;
    assign unused_limit = (STARVE_LIMIT > 0);
    assign starve_hit   = 1'b0;
`else
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
    logic [STARVE_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt >= LIMIT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.i_ext_stb || (decide && pick_state == EXT)) begin
            starve_cnt <= '0;
        end else if (decide && pick_state == CPU && starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    logic [AW-3:0] ram_adr;
    logic [31:0]   ram_dat;
    logic [3:0]    ram_sel;
    logic          ram_we;

    always_comb begin
        ram_adr = '0;
        ram_dat = '0;
        ram_sel = '0;
        ram_we  = 1'b0;
        if (is_ext) begin
            ram_adr = bus.i_ext_adr;
            ram_dat = bus.i_ext_dat;
            ram_sel = bus.i_ext_sel;
            ram_we  = bus.i_ext_we;
        end else if (is_cpu) begin
            ram_adr = bus.i_cpu_adr;
            ram_dat = bus.i_cpu_dat;
            ram_sel = bus.i_cpu_sel;
            ram_we  = bus.i_cpu_we;
        end
    end

    assign bus.o_ram_adr = ram_adr;
    assign bus.o_ram_dat = ram_dat;
    assign bus.o_ram_sel = ram_sel;
    assign bus.o_ram_we  = ram_we;
    assign bus.o_ram_cyc = owner_stb;

    // Ack requires the owner's stb so an abandoned transfer never sees a stray ack.
    assign bus.o_cpu_ack = is_cpu && bus.i_cpu_stb && bus.i_ram_ack;
    assign bus.o_ext_ack = is_ext && bus.i_ext_stb && bus.i_ram_ack;
    assign bus.o_cpu_rdt = is_cpu ? bus.i_ram_rdt : 32'd0;
    assign bus.o_ext_rdt = is_ext ? bus.i_ram_rdt : 32'd0;

    assign bus.sel_radr  = is_ext;
    assign bus.sel_wadr  = is_ext;
    assign bus.sel_wdata = is_ext;
    assign bus.sel_rdata = is_ext;
    assign bus.sel_wen   = is_ext;
    assign bus.o_busy    = (state != IDLE);
    assign bus.dbg_state = state;

endmodule
